// File: rtl/program_data_memory.sv
// Unified 16-bit program/data memory for the S-Machine CPU with a byte-serial
// boot loader that fills the array before releasing the CPU via cpu_enable.
module program_data_memory #(
  parameter int ADDR_W     = 8,
  parameter int LOAD_LIMIT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] PC,
  output logic [15:0]       inst,
  input  logic              enable,
  input  logic              read_write_memory,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_out_memory,
  output logic [15:0]       data_in_memory,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_enable,
  output logic [ADDR_W:0]   loaded_words,
  output logic              load_error
);

  typedef enum logic {LOAD, RUN} state_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(LOAD_LIMIT);

  logic [15:0] mem [2**ADDR_W];

  state_t          state, state_nx;
  logic            phase, phase_nx;
  logic [7:0]      low_byte, low_nx;
  logic [ADDR_W:0] count_nx;
  logic            err_nx;
  logic            ld_we;
  logic [15:0]     ld_wdata;
  logic            cpu_we, cpu_re;
  logic            mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]     mem_wdata;
  logic [15:0]     fetch_word;

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    low_nx   = low_byte;
    count_nx = loaded_words;
    err_nx   = load_error;
    ld_we    = 1'b0;
    ld_wdata = {load_byte, low_byte};
    if (state == LOAD && load_valid) begin
      if (loaded_words >= LIMIT) begin
        err_nx   = 1'b1;
        state_nx = RUN;
      end else if (!phase && !load_last) begin
        low_nx   = load_byte;
        phase_nx = 1'b1;
      end else begin
        // A final byte in phase 0 becomes a zero-extended word of its own.
        ld_we    = 1'b1;
        ld_wdata = phase ? {load_byte, low_byte} : {8'h00, load_byte};
        count_nx = loaded_words + 1'b1;
        phase_nx = 1'b0;
        if (load_last) begin
          state_nx = RUN;
        end else if (count_nx == LIMIT) begin
          state_nx = RUN;
          err_nx   = 1'b1;
        end
      end
    end
  end

  assign cpu_we    = (state == RUN) && enable && read_write_memory;
  assign cpu_re    = (state == RUN) && enable && !read_write_memory;
  assign mem_we    = ld_we || cpu_we;
  assign mem_waddr = (state == LOAD) ? loaded_words[ADDR_W-1:0] : addr;
  assign mem_wdata = (state == LOAD) ? ld_wdata : data_out_memory;
  // Write-first: a fetch of the address being written sees the new data.
  assign fetch_word = (cpu_we && addr == PC) ? data_out_memory : mem[PC];

  assign load_ready = (state == LOAD);
  assign cpu_enable = (state == RUN);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LOAD;
      phase          <= 1'b0;
      low_byte       <= 8'h00;
      loaded_words   <= '0;
      load_error     <= 1'b0;
      inst           <= 16'h0000;
      data_in_memory <= 16'h0000;
    end else begin
      state        <= state_nx;
      phase        <= phase_nx;
      low_byte     <= low_nx;
      loaded_words <= count_nx;
      load_error   <= err_nx;
      if (state == RUN) inst <= fetch_word;
      if (cpu_re) data_in_memory <= mem[addr];
    end
  end

endmodule

// File: doc/program_data_memory.md
Name: program_data_memory

Overview:
- Memory-side responder for the S-Machine CPU.
- Holds one unified 16-bit word array. Serves instruction fetches addressed by the CPU's PC, and data reads/writes driven by the CPU's memory interface.
- After reset, a byte-serial boot loader fills the array from a host stream. Only then does the block release the CPU through cpu_enable.

Parameters:
- ADDR_W, 8, address width; array depth is 2^ADDR_W words of 16 bits.
- LOAD_LIMIT, 256, maximum number of words the loader may write before flagging overflow; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PC  in  ADDR_W  instruction fetch address from the CPU.
- inst  out  16  registered instruction word, mem[PC].
- enable  in  1  CPU memory access strobe.
- read_write_memory  in  1  access type: 1 = write, 0 = read.
- addr  in  ADDR_W  data address.
- data_out_memory  in  16  write data from the CPU.
- data_in_memory  out  16  registered read data to the CPU.
- load_valid  in  1  host byte strobe.
- load_byte  in  8  host byte.
- load_last  in  1  marks the final byte of the image; sampled with load_valid.
- load_ready  out  1  high while in the LOAD state.
- cpu_enable  out  1  high while in the RUN state; gates the CPU.
- loaded_words  out  ADDR_W+1  number of words written by the loader.
- load_error  out  1  sticky overflow flag.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state = LOAD; inst = 0; data_in_memory = 0; loaded_words = 0.
  - Byte-phase = 0; low-byte holding register = 0; load_error = 0.
  - load_ready = 1; cpu_enable = 0.
  - Array contents are NOT reset.
- States: LOAD and RUN.
  - LOAD -> RUN on an accepted byte with load_last = 1, or when loaded_words reaches LOAD_LIMIT.
  - RUN has no exit except reset. Reset mid-load or mid-run returns to LOAD with an empty count.
- LOAD, byte assembly (little-endian):
  - load_valid with phase 0: store load_byte as the low byte; phase becomes 1.
  - load_valid with phase 1: write {load_byte, low} to mem[loaded_words]; loaded_words increments; phase becomes 0.
  - load_last on a phase-0 byte: write {8'h00, load_byte} to the next address, increment loaded_words, go to RUN.
  - load_last on a phase-1 byte: complete that word, then go to RUN.
  - Bytes beyond LOAD_LIMIT words are dropped and set load_error. The same error applies to a byte arriving in the cycle the limit is reached without load_last. The state still moves to RUN.
- LOAD, CPU side: CPU ports are ignored. inst and data_in_memory hold their values.
- RUN, host side: load_valid, load_byte and load_last are ignored. loaded_words is frozen.
- RUN, instruction fetch: inst <= mem[PC] every cycle, one-cycle latency.
- RUN, data write: when enable=1 and read_write_memory=1, mem[addr] <= data_out_memory at the edge. data_in_memory holds its value.
- RUN, data read: when enable=1 and read_write_memory=0, data_in_memory <= mem[addr], one-cycle latency.
- RUN, enable=0: no access; data_in_memory holds.
- Collision rule: a write and a fetch/read of the same address in the same cycle is write-first. inst or data_in_memory returns data_out_memory.
- Address width: addresses are exactly ADDR_W bits, so no out-of-range case exists. loaded_words is one bit wider so it can represent a full array.

Test Plan:
- Reset, then bytes 34,12,78,56 (last on 56) -> mem[0]=16'h1234, mem[1]=16'h5678, loaded_words=2, cpu_enable rises the cycle after the 56 byte, load_error=0.
- Odd image: bytes AB,CD,EF with last on EF -> mem[1]=16'h00EF, loaded_words=2, RUN.
- RUN, PC=1 -> inst=16'h5678 one cycle later. Write addr=5, data 16'hBEEF, rw=1, then read addr=5, rw=0 -> data_in_memory=16'hBEEF one cycle after the read.
- Same-cycle write addr=3, data 16'h0F0F with PC=3 -> next inst=16'h0F0F. enable=0 with rw=1 -> mem unchanged, data_in_memory held.
- LOAD_LIMIT=4, stream 10 bytes without load_last -> 4 words written, RUN entered after the 8th byte, load_error=1, bytes 9-10 ignored.
- Assert rst_n low mid-load after 3 bytes -> outputs return to reset values immediately. A fresh 2-byte load then lands at mem[0].
